alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
//  Parametrised, registered successor of the single-cycle ALU. Adds sra, sltu and the
//  RV32M-style mul/mulhu/div/divu/rem/remu. Long ops run on an iterative datapath.
//  Sits in the execute stage of the multi-cycle core. Stalls the core via a start/busy/done handshake.
// PARAMETERS
//  WIDTH   32  operand/result width; power of 2, >= 8
//  SHW     $clog2(WIDTH)  shift-amount width (derived, not overridable)
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  reset        in   1      synchronous, active-high reset
//  start        in   1      launch op; sampled only in IDLE
//  alu_control  in   4      op select, sampled with start
//  a, b         in   WIDTH  operands, sampled with start; may change afterwards
//  result       out  WIDTH  registered result; holds until next completion
//  zero         out  1      registered, (result == 0); updates with result
//  busy         out  1      high in CALC and DONE; start is ignored while high
//  done         out  1      one-cycle pulse; result/zero are valid from this cycle on
// BEHAVIOUR
//  - Reset is synchronous and active-high. Next state is IDLE, with result=0, zero=1, busy=0, done=0.
//    Reset also aborts an op in progress; no done is produced for the aborted op.
//  - Ops:
//    0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed), 6 sll, 7 srl, 8 sra, 9 sltu,
//    10 mul (low WIDTH bits), 11 mulhu (high WIDTH bits, unsigned),
//    12 div, 13 divu, 14 rem, 15 remu.
//  - Shift ops use b[SHW-1:0]. slt/sltu return {WIDTH-1 zeros, flag}.
//  - Add/sub wrap modulo 2^WIDTH; there is no overflow flag.
//  - FSM states: IDLE, CALC, DONE.
//    IDLE: start with op 0-9 -> compute, register result, go to DONE (done 1 cycle after start).
//    IDLE: start with op 10-15 -> latch operands, clear count, go to CALC.
//    IDLE: start with div/rem and b==0 -> skip CALC, go to DONE (latency 1).
//    CALC: one shift-add (mul) or restoring-subtract (div) step per cycle.
//          count runs 0..WIDTH-1; after WIDTH steps -> DONE.
//          Mul/div done therefore arrives WIDTH+1 cycles after start.
//    DONE: done=1 for exactly this cycle, then -> IDLE.
//          A start seen in DONE is ignored; the earliest next start is accepted one cycle after done.
//  - Multiply: unsigned 2*WIDTH product of a and b. mul returns bits [WIDTH-1:0]; mulhu returns [2W-1:W].
//  - Signed divide: divide magnitudes, then negate q if sign(a)!=sign(b), and negate r if a<0.
//  - Divide by zero: div/divu -> all ones; rem/remu -> a.
//  - Signed overflow (a = -2^(W-1), b = -1): div -> a, rem -> 0. Both go through normal CALC latency.
//  - result/zero change only on the cycle entering DONE; they are stable at all other times.
// TESTING (WIDTH=32 unless noted)
//  1. Reset mid-CALC: start divu 100/7, assert reset on cycle 5.
//     -> next cycle busy=0, done=0, result=0, zero=1; no later done.
//  2. Single-cycle ops:
//     sub 5-5 -> done at +1, result 0, zero=1.
//     sra 0x80000000>>4 -> 0xF8000000.
//     sltu 1 vs 0xFFFFFFFF -> 1; slt 1 vs 0xFFFFFFFF -> 0.
//  3. Multiply:
//     mul 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, done at exactly +33.
//     mulhu of the same operands -> 0xFFFFFFFE.
//  4. Signed divide:
//     div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1).
//     div 0x80000000/-1 -> 0x80000000; rem of the same -> 0.
//  5. Divide by zero: divu 42/0 -> 0xFFFFFFFF and remu 42/0 -> 42, both with done at +1.
//  6. Handshake: pulse start every cycle during a mul; only the first is accepted.
//     Operand changes after start do not affect result. Repeat ops 2-5 with WIDTH=8 against a reference model.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: registered ALU with an iterative multiply/divide datapath.
// Single-cycle ops finish one cycle after start. mul/mulhu/div/divu/rem/remu
// take one shift-add or restoring-subtract step per cycle in CALC.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [3:0]       op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  // hi/lo hold {product high, product low / multiplier} for mul and
  // {partial remainder, dividend-shifting-into-quotient} for div.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        alu_res;
  logic [WIDTH:0]          mul_sum, rem_sh, diff;
  logic [WIDTH-1:0]        step_hi, step_lo, fin;
  logic                    is_mul;

  // Two's-complement negate when n is set; used for magnitudes and sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SHW-1:0];

  // Single-cycle op results, computed straight from the live operands.
  always_comb begin
    alu_res = '0;
    case (alu_control)
      4'd0:    alu_res = a + b;
      4'd1:    alu_res = a - b;
      4'd2:    alu_res = a & b;
      4'd3:    alu_res = a | b;
      4'd4:    alu_res = a ^ b;
      4'd5:    alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd6:    alu_res = a << shamt;
      4'd7:    alu_res = a >> shamt;
      4'd8:    alu_res = $unsigned(a_s >>> shamt);
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // One iteration of the multiply or divide datapath, plus the final result
  // selection used on the last iteration.
  always_comb begin
    is_mul  = (op_q[3:1] == 3'b101);
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
    case (op_q)
      4'd10:   fin = step_lo;
      4'd11:   fin = step_hi;
      4'd12:   fin = cond_neg(step_lo, qneg_q);
      4'd13:   fin = step_lo;
      4'd14:   fin = cond_neg(step_hi, rneg_q);
      default: fin = step_hi;
    endcase
  end

  // FSM next state, operand capture and result registration.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (alu_control < 4'd10) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = DONE;
          end else if ((alu_control[3:2] == 2'b11) && (b == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            result_d = alu_control[1] ? a : '1;
            zero_d   = alu_control[1] ? (a == '0) : 1'b0;
            state_d  = DONE;
          end else begin
            op_d    = alu_control;
            count_d = '0;
            state_d = CALC;
            hi_d    = '0;
            if (alu_control[3:1] == 3'b101) begin
              lo_d  = b;
              dvs_d = a;
            end else begin
              // Signed div/rem run on magnitudes; signs are re-applied at the end.
              lo_d   = cond_neg(a, ~alu_control[0] & a[WIDTH-1]);
              dvs_d  = cond_neg(b, ~alu_control[0] & b[WIDTH-1]);
              qneg_d = ~alu_control[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d = ~alu_control[0] & a[WIDTH-1];
            end
          end
        end
      end
      CALC: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + 1'b1;
        if (count_q == SHW'(WIDTH-1)) begin
          result_d = fin;
          zero_d   = (fin == '0);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= 4'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Iterative datapath registers; contents are don't-care outside CALC.
  always_ff @(posedge clk) begin
    hi_q  <= hi_d;
    lo_q  <= lo_d;
    dvs_q <= dvs_d;
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule
